// File: rtl/key_reader_pkg.sv
// Shared types and constants for the pushbutton/switch reader.
package key_reader_pkg;

  localparam int unsigned N_KEYS              = 4;
  localparam int unsigned N_SW                = 10;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, debounce FSM, press/release pulses.
// Auto-repeat of press pulses is built only when KEY_READER_REPEAT_EN is defined.
module key_debounce
  import key_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          pressed;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          press_q, press_d, release_q, release_d;
  logic          accept_press;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // The sample that leaves a stable state counts as the first stable sample,
  // so DEBOUNCE_CYCLES == 1 skips the wait state entirely.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    release_d    = 1'b0;
    accept_press = 1'b0;
    case (state_q)
      RELEASED: begin
        if (pressed) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d      = PRESSED;
            accept_press = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d      = PRESSED;
          cnt_d        = '0;
          accept_press = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = RELEASED;
            release_d = 1'b1;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_READER_REPEAT_EN
  localparam int unsigned   RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned   RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic          rep_arm_q, rep_arm_d, rep_first_q, rep_first_d;
  logic          hold_press, leave_press, rep_fire;

  assign hold_press  = (state_q == PRESSED) && pressed;
  assign leave_press = (state_q == PRESSED) && !pressed;
  assign rep_inc     = rep_cnt_q + 1'b1;

  // Disarmed on leaving PRESSED; a bounce back from RELEASE_WAIT keeps it off.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_arm_d   = rep_arm_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    if (accept_press) begin
      rep_arm_d   = 1'b1;
      rep_first_d = 1'b1;
      rep_cnt_d   = '0;
    end else if (leave_press) begin
      rep_arm_d = 1'b0;
      rep_cnt_d = '0;
    end else if (hold_press && rep_arm_q) begin
      if (rep_inc == (rep_first_q ? RDLY : RPER)) begin
        rep_fire    = 1'b1;
        rep_first_d = 1'b0;
        rep_cnt_d   = '0;
      end else begin
        rep_cnt_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q   <= '0;
      rep_arm_q   <= 1'b0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_arm_q   <= rep_arm_d;
      rep_first_q <= rep_first_d;
    end
  end

  assign press_d = accept_press | rep_fire;
`else
  assign press_d = accept_press;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_reader.sv
// DE-series pushbutton and switch front end: four debounced keys plus synchronized switches.
// Define KEY_READER_REPEAT_EN to enable key auto-repeat.
module key_reader
  import key_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [N_KEYS-1:0] KEY,
  input  logic [N_SW-1:0]   SW,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_SW-1:0]   sw_sync,
  output logic              sw_change
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_key_debounce (
      .clk_i    (CLOCK_50),
      .rst_ni   (resetn),
      .key_n_i  (KEY[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i])
    );
  end

  logic [N_SW-1:0] sw_meta_q, sw_sync_q, sw_prev_q;
  logic            sw_change_q, sw_change_d;

  always_comb begin
    sw_change_d = |(sw_sync_q ^ sw_prev_q);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sw_prev_q   <= '0;
      sw_change_q <= 1'b0;
    end else begin
      sw_meta_q   <= SW;
      sw_sync_q   <= sw_meta_q;
      sw_prev_q   <= sw_sync_q;
      sw_change_q <= sw_change_d;
    end
  end

  assign sw_sync   = sw_sync_q;
  assign sw_change = sw_change_q;

endmodule

// File: tb/tb_key_reader.sv
// Directed bench for key_reader (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3);
// every pulse is matched against a queue of expected (cycle, press, release, sw_change) events.
module tb_key_reader;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [3:0] key_level, key_press, key_release;
  logic [9:0] sw_sync;
  logic       sw_change;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic       swc;
  } ev_t;

  ev_t sb[$];

  key_reader #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .KEY        (KEY),
    .SW         (SW),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .sw_sync    (sw_sync),
    .sw_change  (sw_change)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (key_press != 4'b0 || key_release != 4'b0 || sw_change) begin
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{cyc: -1, press: 4'b0, rel: 4'b0, swc: 1'b0};
      checks++;
      assert (cyc === e.cyc && key_press === e.press && key_release === e.rel && sw_change === e.swc)
      else begin
        errors++;
        $error("FAIL pulse: observed cyc=%0d press=%b release=%b swc=%b, expected cyc=%0d press=%b release=%b swc=%b",
               cyc, key_press, key_release, sw_change, e.cyc, e.press, e.rel, e.swc);
      end
    end
  end

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic s);
    sb.push_back('{cyc: c, press: p, rel: r, swc: s});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int c0;
    int r;

    // Reset with KEY[3] held and switches non-zero
    resetn = 1'b0;
    KEY    = 4'b0111;
    SW     = 10'h005;
    step(3);
    check("rst_level",   32'(key_level),   32'h0);
    check("rst_press",   32'(key_press),   32'h0);
    check("rst_release", 32'(key_release), 32'h0);
    check("rst_sw_sync", 32'(sw_sync),     32'h0);
    check("rst_sw_chg",  32'(sw_change),   32'h0);
    resetn = 1'b1;
    r = cyc;
    push(r + 3, 4'b0000, 4'b0000, 1'b1);
    push(r + 6, 4'b1000, 4'b0000, 1'b0);
    step(1);
    check("post_rst_sw_sync1", 32'(sw_sync), 32'h0);
    step(1);
    check("post_rst_sw_sync2", 32'(sw_sync), 32'h005);
    step(6);
    check("held_thru_rst_level", 32'(key_level), 32'h8);
    KEY = 4'hF;
    push(r + 14, 4'b0000, 4'b1000, 1'b0);
    step(10);
    check("held_thru_rst_released", 32'(key_level), 32'h0);

    // Switch change
    SW = 10'h201;
    c0 = cyc;
    push(c0 + 3, 4'b0000, 4'b0000, 1'b1);
    step(1);
    check("sw_sync_c1", 32'(sw_sync), 32'h005);
    step(1);
    check("sw_sync_c2", 32'(sw_sync), 32'h201);
    step(6);

    // Clean press on KEY[1]
    KEY = 4'b1101;
    c0 = cyc;
    push(c0 + 6, 4'b0010, 4'b0000, 1'b0);
    step(5);
    check("clean_level_c5", 32'(key_level), 32'h0);
    step(1);
    check("clean_level_c6", 32'(key_level), 32'h2);
    check("clean_press_c6", 32'(key_press), 32'h2);
    step(4);
    KEY = 4'hF;
    push(c0 + 16, 4'b0000, 4'b0010, 1'b0);
    step(12);

    // Bounce on KEY[0]: low 3, high 1, then low
    KEY = 4'b1110;
    c0 = cyc;
    step(3);
    KEY = 4'b1111;
    step(1);
    KEY = 4'b1110;
    push(c0 + 10, 4'b0001, 4'b0000, 1'b0);
    step(6);
    check("bounce_level", 32'(key_level), 32'h1);
    step(2);
    KEY = 4'hF;
    push(c0 + 18, 4'b0000, 4'b0001, 1'b0);
    step(10);

    // Simultaneous KEY[2]/KEY[3]
    KEY = 4'b0011;
    c0 = cyc;
    push(c0 + 6, 4'b1100, 4'b0000, 1'b0);
    step(8);
    KEY = 4'hF;
    c0 = cyc;
    push(c0 + 6, 4'b0000, 4'b1100, 1'b0);
    step(5);
    check("simul_level_held", 32'(key_level), 32'hC);
    step(1);
    check("simul_level_rel", 32'(key_level),   32'h0);
    check("simul_release",   32'(key_release), 32'hC);
    step(8);

    // Long hold on KEY[0]: auto-repeat only when enabled
    KEY = 4'b1110;
    c0 = cyc;
    push(c0 + 6, 4'b0001, 4'b0000, 1'b0);
`ifdef KEY_READER_REPEAT_EN
    push(c0 + 16, 4'b0001, 4'b0000, 1'b0);
    push(c0 + 19, 4'b0001, 4'b0000, 1'b0);
    push(c0 + 22, 4'b0001, 4'b0000, 1'b0);
`endif
    step(20);
    KEY = 4'hF;
    push(c0 + 26, 4'b0000, 4'b0001, 1'b0);
    step(12);
    check("hold_level_after", 32'(key_level), 32'h0);

    // Reset in the middle of a KEY[0] debounce
    KEY = 4'b1110;
    step(3);
    resetn = 1'b0;
    step(1);
    check("mid_rst_level", 32'(key_level), 32'h0);
    step(1);
    resetn = 1'b1;
    r = cyc;
    push(r + 3, 4'b0000, 4'b0000, 1'b1);
    push(r + 6, 4'b0001, 4'b0000, 1'b0);
    step(8);
    check("mid_rst_level_after", 32'(key_level), 32'h1);
    KEY = 4'hF;
    push(r + 14, 4'b0000, 4'b0001, 1'b0);
    step(12);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_reader.md
KEY_READER -- requirements
Module: key_reader

Interface
REQ-001 The block SHALL have the parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable clock cycles needed to accept a key change; its legal range is 1 or more.
REQ-002 The block SHALL have the parameter REPEAT_DELAY, default 25000000, meaning the cycles from an accepted press to the first auto-repeat pulse.
REQ-003 The block SHALL have the parameter REPEAT_PERIOD, default 5000000, meaning the cycles between later auto-repeat pulses.
REQ-004 The block SHALL have the port CLOCK_50, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port resetn, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have the port KEY, input, width 4: raw DE-series pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-007 The block SHALL have the port SW, input, width 10: raw DE-series switches, asynchronous to CLOCK_50.
REQ-008 The block SHALL have the port key_level, output, width 4: debounced key state, active-high (1 = held).
REQ-009 The block SHALL have the port key_press, output, width 4: one-cycle pulse per accepted press (and per auto-repeat).
REQ-010 The block SHALL have the port key_release, output, width 4: one-cycle pulse per accepted release.
REQ-011 The block SHALL have the port sw_sync, output, width 10: synchronized switch values.
REQ-012 The block SHALL have the port sw_change, output, width 1: one-cycle pulse when any sw_sync bit differs from its value in the previous cycle.

Function
REQ-013 Each KEY bit and each SW bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Each key SHALL be handled by an independent FSM with the states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-015 The key FSM transitions SHALL be:
- RELEASED to PRESS_WAIT when the synchronized key reads pressed; the stability counter loads to 1.
- PRESS_WAIT to RELEASED, with no pulse, if the synchronized key reads released before the counter reaches DEBOUNCE_CYCLES.
- PRESS_WAIT to PRESSED when the counter reaches DEBOUNCE_CYCLES; otherwise the counter increments.
- PRESSED to RELEASE_WAIT and RELEASE_WAIT to RELEASED follow the same rules with the polarity mirrored.
REQ-016 key_press[i] SHALL be high for exactly the one cycle after entry into PRESSED; key_release[i] SHALL be high for exactly the one cycle after entry into RELEASED from RELEASE_WAIT.
REQ-017 key_level[i] SHALL be 1 in PRESSED and RELEASE_WAIT, and 0 otherwise.
REQ-018 Latency: with a clean edge at KEY[i] in cycle 0, key_press[i] SHALL assert in cycle 2+DEBOUNCE_CYCLES.
REQ-019 If DEBOUNCE_CYCLES is 1, a single stable sample SHALL be accepted, with no extra wait cycle.
REQ-020 The stability counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL saturate, never wrapping.
REQ-021 Keys SHALL be fully independent; simultaneous presses on several keys SHALL give simultaneous pulses in the same cycle.
REQ-022 key_press[i] and key_release[i] SHALL never both be high in the same cycle.
REQ-023 sw_change SHALL be registered: it is high in the cycle after sw_sync changes.
REQ-024 sw_change SHALL pulse once per cycle in which any number of sw_sync bits change.
REQ-025 Switches SHALL NOT be debounced.

Reset
REQ-026 While resetn is 0, every FSM SHALL be in RELEASED and every counter SHALL be 0.
REQ-027 While resetn is 0, the key synchronizers SHALL hold 1 (released), and the switch synchronizers and all outputs SHALL hold 0.
REQ-028 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse, in the same cycle or asynchronously.
REQ-029 A key held through the deassertion of reset SHALL be treated as a new press: it produces one key_press after 2+DEBOUNCE_CYCLES cycles.
REQ-030 A switch that is at 1 when reset deasserts SHALL produce one sw_change pulse after synchronization; this is required behaviour.

Configuration
REQ-031 With the macro KEY_READER_REPEAT_EN defined, a key in PRESSED SHALL re-pulse key_press REPEAT_DELAY cycles after the entry pulse, and then every REPEAT_PERIOD cycles while the key remains in PRESSED.
REQ-032 With KEY_READER_REPEAT_EN defined, entering RELEASE_WAIT SHALL stop and clear the repeat counter, and it SHALL stay stopped if the FSM returns to PRESSED.
REQ-033 Without KEY_READER_REPEAT_EN, the block SHALL contain no repeat logic, REPEAT_DELAY and REPEAT_PERIOD SHALL be accepted but ignored, and exactly one key_press SHALL occur per accepted press.

Structure
REQ-034 The package key_reader_pkg SHALL hold the FSM state enum key_state_t, the constants N_KEYS=4 and N_SW=10, and the default debounce and repeat constants.
REQ-035 The per-key synchronizer, FSM, counters and pulse logic SHALL form the sub-module key_debounce, instantiated four times by a generate loop.
REQ-036 The switch synchronizer and sw_change logic SHALL reside in key_reader.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-037 Clean press: KEY[1] goes 1->0 at cycle 0 and is held -> key_press[1] is high in cycle 6 only, key_level[1] is 1 from cycle 6, and key_release stays 0.
REQ-038 Bounce: KEY[0] is low for 3 cycles, high for 1, then low and held -> no pulse within the first 4 cycles, and key_press[0] asserts once, 6 cycles after the final falling edge.
REQ-039 Release plus simultaneity: KEY[2] and KEY[3] are held, then both released at the same cycle -> key_release is 4'b1100 for exactly one cycle, 6 cycles later, and key_level becomes 4'b0000.
REQ-040 Reset mid-debounce: KEY[0] goes low, resetn pulses low at cycle 3 and KEY stays low -> no pulse before reset, and key_press[0] occurs 6 cycles after resetn rises.
REQ-041 Switches: SW changes 10'h000 -> 10'h201 at cycle 0 -> sw_sync equals 10'h201 from cycle 2, and sw_change is high in cycle 3 only.
REQ-042 With KEY_READER_REPEAT_EN defined: KEY[0] is held -> key_press[0] pulses at cycles 6, 16, 19 and 22, and stops after the release is accepted.
